// File: rtl/vfpu_alu_pipe_pkg.sv
// Shared types for the vector integer ALU pipeline: operation codes, FSM states, lane width.
// The saturating helper is only referenced when VFPU_SAT_EN is defined.
package vfpu_package;

   localparam int unsigned VFPU_LANE_W = 32;

   typedef enum logic [2:0] {
      VFPU_ADD = 3'd0,
      VFPU_SUB = 3'd1,
      VFPU_MUL = 3'd2,
      VFPU_MIN = 3'd3,
      VFPU_MAX = 3'd4
   } vfpu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } vfpu_state_t;

   // Clamp a 33-bit sign-extended sum/difference to the signed 32-bit range.
   function automatic logic [31:0] vfpu_sat32(input logic [32:0] x);
      if (x[32] != x[31]) begin
         return x[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return x[31:0];
   endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle carrying data plus a per-byte strobe.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport master (output valid, output data, output strb, input ready);
   modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/vfpu_alu_pipe_lane.sv
// Combinational 32-bit lane ALU: ADD/SUB/MUL/MIN/MAX, zero for undefined codes.
// VFPU_SAT_EN selects saturating ADD/SUB instead of modulo-2^32 wrap.
module vfpu_lane
   import vfpu_package::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] r
);

   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic [31:0] mul_res;

`ifdef VFPU_SAT_EN
   logic [32:0] sum_wide;
   logic [32:0] diff_wide;

   assign sum_wide  = {a[31], a} + {b[31], b};
   assign diff_wide = {a[31], a} - {b[31], b};
   assign add_res   = vfpu_sat32(sum_wide);
   assign sub_res   = vfpu_sat32(diff_wide);
`else
   assign add_res = a + b;
   assign sub_res = a - b;
`endif

   // Low half of the product is identical for signed and unsigned operands.
   assign mul_res = a * b;

   always_comb begin
      r = '0;
      case (op)
         VFPU_ADD: r = add_res;
         VFPU_SUB: r = sub_res;
         VFPU_MUL: r = mul_res;
         VFPU_MIN: r = ($signed(a) < $signed(b)) ? a : b;
         VFPU_MAX: r = ($signed(a) < $signed(b)) ? b : a;
         default:  r = '0;
      endcase
   end

endmodule

// File: rtl/vfpu_alu_pipe.sv
// Joins two operand streams, applies a per-lane integer op, and delivers results through
// an elastic PIPE_DEPTH-stage pipeline; counts beats against a job length. Option: VFPU_SAT_EN.
module vfpu_alu_pipe
   import vfpu_package::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PIPE_DEPTH = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [CNT_WIDTH-1:0]  len_i,
   hwpe_stream_intf_stream.slave  a_i,
   hwpe_stream_intf_stream.slave  b_i,
   hwpe_stream_intf_stream.master r_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

   localparam int unsigned LANES  = DATA_WIDTH / VFPU_LANE_W;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned LAST   = PIPE_DEPTH - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   vfpu_state_t state_reg;
   vfpu_state_t state_next;

   logic [2:0]           op_reg;
   logic [CNT_WIDTH-1:0] len_reg;
   logic [CNT_WIDTH-1:0] issued_reg;
   logic [CNT_WIDTH-1:0] delivered_reg;

   logic [DATA_WIDTH-1:0] alu_data;
   logic [STRB_W-1:0]     join_strb;
   logic                  fire;
   logic                  out_hs;

   logic [PIPE_DEPTH-1:0] valid_reg;
   logic [DATA_WIDTH-1:0] data_reg [PIPE_DEPTH];
   logic [STRB_W-1:0]     strb_reg [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] in_valid;
   logic [DATA_WIDTH-1:0] in_data  [PIPE_DEPTH];
   logic [STRB_W-1:0]     in_strb  [PIPE_DEPTH];
   logic [PIPE_DEPTH:0]   move;

   genvar gi;

   // Results are formed combinationally ahead of stage 0.
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         vfpu_lane u_lane (
            .op (op_reg),
            .a  (a_i.data[gi*VFPU_LANE_W +: VFPU_LANE_W]),
            .b  (b_i.data[gi*VFPU_LANE_W +: VFPU_LANE_W]),
            .r  (alu_data[gi*VFPU_LANE_W +: VFPU_LANE_W])
         );
      end
   endgenerate

   assign join_strb = a_i.strb & b_i.strb;

   // A stage may load when it is empty or its content moves on this cycle.
   always_comb begin
      move             = '0;
      move[PIPE_DEPTH] = r_o.ready;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         move[k] = ~valid_reg[k] | move[k+1];
      end
   end

   assign fire      = (state_reg == RUN) & a_i.valid & b_i.valid & move[0];
   assign a_i.ready = fire;
   assign b_i.ready = fire;
   assign out_hs    = valid_reg[LAST] & r_o.ready;

   generate
      for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage_in
         if (gi == 0) begin : g_head
            assign in_valid[gi] = fire;
            assign in_data[gi]  = alu_data;
            assign in_strb[gi]  = join_strb;
         end else begin : g_body
            assign in_valid[gi] = valid_reg[gi-1];
            assign in_data[gi]  = data_reg[gi-1];
            assign in_strb[gi]  = strb_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_reg <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            data_reg[k] <= '0;
            strb_reg[k] <= '0;
         end
      end else if (clear_i) begin
         valid_reg <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            data_reg[k] <= '0;
            strb_reg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (move[k]) begin
               valid_reg[k] <= in_valid[k];
               if (in_valid[k]) begin
                  data_reg[k] <= in_data[k];
                  strb_reg[k] <= in_strb[k];
               end
            end
         end
      end
   end

   assign r_o.valid = valid_reg[LAST];
   assign r_o.data  = data_reg[LAST];
   assign r_o.strb  = strb_reg[LAST];

   always_comb begin
      state_next = state_reg;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = (len_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (fire && ((issued_reg + CNT_ONE) == len_reg)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (out_hs && ((delivered_reg + CNT_ONE) == len_reg)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         op_reg        <= '0;
         len_reg       <= '0;
         issued_reg    <= '0;
         delivered_reg <= '0;
      end else if (clear_i) begin
         state_reg     <= IDLE;
         op_reg        <= '0;
         len_reg       <= '0;
         issued_reg    <= '0;
         delivered_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start_i) begin
            op_reg        <= op_i;
            len_reg       <= len_i;
            issued_reg    <= '0;
            delivered_reg <= '0;
         end else begin
            if (fire) begin
               issued_reg <= issued_reg + CNT_ONE;
            end
            if (out_hs) begin
               delivered_reg <= delivered_reg + CNT_ONE;
            end
         end
      end
   end

   assign beat_cnt_o = delivered_reg;

endmodule

// File: tb/tb_vfpu_alu_pipe.sv
// Randomized self-checking bench for vfpu_alu_pipe (2 lanes, depth 2) against a
// behavioural per-lane arithmetic model and an in-order result scoreboard.
module tb_vfpu_alu_pipe;
   import vfpu_package::*;

   localparam int DW     = 64;
   localparam int PD     = 2;
   localparam int CW     = 16;
   localparam int SW     = DW / 8;
   localparam int LANES  = DW / 32;
   localparam int BUDGET = 3000;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          start;
   logic [2:0]    op;
   logic [CW-1:0] len;
   logic          busy;
   logic          done;
   logic [CW-1:0] beat_cnt;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) a_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) b_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) r_if ();

   vfpu_alu_pipe #(.DATA_WIDTH(DW), .PIPE_DEPTH(PD), .CNT_WIDTH(CW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear),
      .start_i    (start),
      .op_i       (op),
      .len_i      (len),
      .a_i        (a_if),
      .b_i        (b_if),
      .r_o        (r_if),
      .busy_o     (busy),
      .done_o     (done),
      .beat_cnt_o (beat_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] stim_a[$];
   logic [DW-1:0] stim_b[$];
   logic [SW-1:0] stim_sa[$];
   logic [SW-1:0] stim_sb[$];
   logic [DW-1:0] got_d[$];
   logic [SW-1:0] got_s[$];

   int a_pct = 100, b_pct = 100, r_pct = 100, inject_cyc = -1;
   int fire_count, rvalid_count, ready_mismatch, unstable, done_pulses;
   int first_fire, first_valid, done_cyc, beat_end;
   bit timed_out, busy_at_inject;

   // Arithmetic reference on mathematical integers, then reduced to 32 bits.
   function automatic logic [31:0] lane_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, s;
      logic [63:0] s_bits;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         3'd0: s = sa + sb;
         3'd1: s = sa - sb;
         3'd2: s = sa * sb;
         3'd3: s = (sa < sb) ? sa : sb;
         3'd4: s = (sa > sb) ? sa : sb;
         default: return 32'h0;
      endcase
`ifdef VFPU_SAT_EN
      if (f == 3'd0 || f == 3'd1) begin
         if (s > 64'sd2147483647)  s = 64'sd2147483647;
         if (s < -64'sd2147483648) s = -64'sd2147483648;
      end
`endif
      s_bits = s;
      return s_bits[31:0];
   endfunction

   function automatic logic [DW-1:0] beat_model(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         r[l*32 +: 32] = lane_model(f, a[l*32 +: 32], b[l*32 +: 32]);
      end
      return r;
   endfunction

   task automatic clear_stim();
      stim_a.delete(); stim_b.delete(); stim_sa.delete(); stim_sb.delete();
   endtask

   // Drives one job and records observations; comparisons happen in the calling tests.
   task automatic run_stream(input logic [2:0] job_op, input int job_len, input bit force_valid);
      bit av, bv, done_seen, stall_prev;
      int i, post;
      logic [DW-1:0] stall_d;
      logic [SW-1:0] stall_s;
      got_d.delete(); got_s.delete();
      fire_count = 0; rvalid_count = 0; ready_mismatch = 0; unstable = 0; done_pulses = 0;
      first_fire = -1; first_valid = -1; done_cyc = -1; busy_at_inject = 0;
      av = 0; bv = 0; done_seen = 0; stall_prev = 0; i = 0; post = 0;
      stall_d = '0; stall_s = '0;
      @(posedge clk); #1;
      start = 1'b1; op = job_op; len = CW'(job_len);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         start = (cyc == inject_cyc);
         if (cyc == inject_cyc) begin
            op  = VFPU_SUB;
            len = CW'(1);
         end
         if (!av) av = force_valid || (i < job_len && int'($urandom_range(99)) < a_pct);
         if (!bv) bv = force_valid || (i < job_len && int'($urandom_range(99)) < b_pct);
         a_if.valid = av;
         b_if.valid = bv;
         a_if.data  = (i < job_len) ? stim_a[i]  : '0;
         b_if.data  = (i < job_len) ? stim_b[i]  : '0;
         a_if.strb  = (i < job_len) ? stim_sa[i] : '0;
         b_if.strb  = (i < job_len) ? stim_sb[i] : '0;
         r_if.ready = (int'($urandom_range(99)) < r_pct);
         @(negedge clk);
         if (a_if.ready !== b_if.ready) ready_mismatch++;
         if (a_if.ready === 1'b1) begin
            if (first_fire < 0) first_fire = cyc;
            fire_count++;
            i++;
            av = 0;
            bv = 0;
         end
         if (stall_prev && (r_if.valid !== 1'b1 || r_if.data !== stall_d || r_if.strb !== stall_s)) unstable++;
         stall_prev = (r_if.valid === 1'b1) && (r_if.ready !== 1'b1);
         stall_d = r_if.data;
         stall_s = r_if.strb;
         if (r_if.valid === 1'b1) begin
            rvalid_count++;
            if (first_valid < 0) first_valid = cyc;
            if (r_if.ready === 1'b1) begin
               got_d.push_back(r_if.data);
               got_s.push_back(r_if.strb);
            end
         end
         if (cyc == inject_cyc) busy_at_inject = busy;
         if (done_seen) post++;
         if (done === 1'b1) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
            done_seen = 1;
         end
         if (post >= 3) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      a_if.valid = 1'b0;
      b_if.valid = 1'b0;
      r_if.ready = 1'b0;
      beat_end   = int'(beat_cnt);
      timed_out  = !done_seen;
      inject_cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_if.valid = 1'b1; b_if.valid = 1'b1; r_if.ready = 1'b1;
      a_if.data = {$urandom, $urandom}; b_if.data = {$urandom, $urandom};
      a_if.strb = '1; b_if.strb = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (r_if.valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", r_if.valid); end
      checks++; if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", a_if.ready, b_if.ready); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
      checks++; if (beat_cnt !== '0) begin errors++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
      checks++; if (r_if.data !== '0 || r_if.strb !== '0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", r_if.data, r_if.strb); end
      rst = 1'b0;
      a_if.valid = 1'b0; b_if.valid = 1'b0; r_if.ready = 1'b0;
      @(posedge clk); #1;
      $display("reset: checked idle outputs");
   endtask

   task automatic test_add_basic();
      clear_stim();
      for (int i = 0; i < 4; i++) begin
         stim_a.push_back({$urandom, 32'(i + 1)});
         stim_b.push_back({$urandom, 32'(10 * (i + 1))});
         stim_sa.push_back('1);
         stim_sb.push_back('1);
      end
      a_pct = 100; b_pct = 100; r_pct = 100;
      run_stream(VFPU_ADD, 4, 1'b0);
      checks++; if (timed_out) begin errors++; $display("FAIL add_timeout got=timeout exp=done"); end
      checks++; if (got_d.size() != 4) begin errors++; $display("FAIL add_count got=%0d exp=4", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         checks++;
         if (got_d[i][31:0] !== 32'(11 * (i + 1)) || got_d[i] !== beat_model(VFPU_ADD, stim_a[i], stim_b[i])) begin
            errors++; $display("FAIL add_beat%0d got=%h exp=%h", i, got_d[i], beat_model(VFPU_ADD, stim_a[i], stim_b[i]));
         end
      end
      checks++; if (first_valid - first_fire != PD) begin errors++; $display("FAIL add_latency got=%0d exp=%0d", first_valid - first_fire, PD); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL add_done_pulses got=%0d exp=1", done_pulses); end
      checks++; if (beat_end != 4) begin errors++; $display("FAIL add_beat_cnt got=%0d exp=4", beat_end); end
      $display("add_basic: 4 beats, latency %0d", first_valid - first_fire);
   endtask

   task automatic test_saturation();
      logic [31:0] exp_sub, exp_add;
`ifdef VFPU_SAT_EN
      exp_sub = 32'h8000_0000;
      exp_add = 32'h7FFF_FFFF;
`else
      exp_sub = 32'h7FFF_FFFF;
      exp_add = 32'h8000_0000;
`endif
      clear_stim();
      stim_a.push_back({32'd5, 32'h8000_0000}); stim_b.push_back({32'd7, 32'd1});
      stim_sa.push_back('1); stim_sb.push_back('1);
      run_stream(VFPU_SUB, 1, 1'b0);
      checks++;
      if (got_d.size() != 1 || got_d[0] !== {32'hFFFF_FFFE, exp_sub}) begin
         errors++; $display("FAIL sub_min_edge got=%h exp=%h", (got_d.size() > 0) ? got_d[0] : '0, {32'hFFFF_FFFE, exp_sub});
      end
      $display("sat_sub: 0x80000000-1 exp=%h", exp_sub);
      clear_stim();
      stim_a.push_back({32'd3, 32'h7FFF_FFFF}); stim_b.push_back({32'd4, 32'd1});
      stim_sa.push_back('1); stim_sb.push_back('1);
      run_stream(VFPU_ADD, 1, 1'b0);
      checks++;
      if (got_d.size() != 1 || got_d[0] !== {32'd7, exp_add}) begin
         errors++; $display("FAIL add_max_edge got=%h exp=%h", (got_d.size() > 0) ? got_d[0] : '0, {32'd7, exp_add});
      end
      $display("sat_add: 0x7FFFFFFF+1 exp=%h", exp_add);
   endtask

   task automatic test_mul_min_max();
      logic [2:0]  ops [4];
      logic [31:0] exp0;
      ops[0] = VFPU_MUL; ops[1] = VFPU_MIN; ops[2] = VFPU_MAX; ops[3] = 3'd6;
      for (int t = 0; t < 4; t++) begin
         case (t)
            0: exp0 = 32'hFFFF_FFF1;
            1: exp0 = 32'hFFFF_FFFD;
            2: exp0 = 32'd5;
            default: exp0 = 32'd0;
         endcase
         clear_stim();
         stim_a.push_back({$urandom, 32'hFFFF_FFFD}); stim_b.push_back({$urandom, 32'd5});
         stim_sa.push_back(8'h0F); stim_sb.push_back(8'h03);
         run_stream(ops[t], 1, 1'b0);
         checks++;
         if (got_d.size() != 1 || got_d[0][31:0] !== exp0 || got_d[0] !== beat_model(ops[t], stim_a[0], stim_b[0])) begin
            errors++; $display("FAIL op%0d_data got=%h exp=%h", ops[t], (got_d.size() > 0) ? got_d[0] : '0, beat_model(ops[t], stim_a[0], stim_b[0]));
         end
         checks++;
         if (got_s.size() != 1 || got_s[0] !== 8'h03) begin
            errors++; $display("FAIL op%0d_strb got=%h exp=03", ops[t], (got_s.size() > 0) ? got_s[0] : '0);
         end
         $display("op %0d: lane0 exp=%h", ops[t], exp0);
      end
   endtask

   task automatic test_random();
      logic [2:0] rop;
      logic [31:0] corner [4];
      corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0;
      for (int round = 0; round < 3; round++) begin
         rop = 3'($urandom_range(4));
         clear_stim();
         for (int i = 0; i < 64; i++) begin
            stim_a.push_back({$urandom, ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : 32'($urandom)});
            stim_b.push_back({$urandom, ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : 32'($urandom)});
            stim_sa.push_back(SW'($urandom));
            stim_sb.push_back(SW'($urandom));
         end
         a_pct = 60; b_pct = 70; r_pct = 50;
         run_stream(rop, 64, 1'b0);
         checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout got=timeout exp=done", round); end
         checks++; if (got_d.size() != 64) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=64", round, got_d.size()); end
         for (int i = 0; i < got_d.size() && i < 64; i++) begin
            checks++;
            if (got_d[i] !== beat_model(rop, stim_a[i], stim_b[i]) || got_s[i] !== (stim_sa[i] & stim_sb[i])) begin
               errors++; $display("FAIL rnd%0d_beat%0d got=%h/%h exp=%h/%h", round, i, got_d[i], got_s[i],
                                  beat_model(rop, stim_a[i], stim_b[i]), stim_sa[i] & stim_sb[i]);
            end
         end
         checks++; if (ready_mismatch != 0) begin errors++; $display("FAIL rnd%0d_ready_pair got=%0d exp=0", round, ready_mismatch); end
         checks++; if (unstable != 0) begin errors++; $display("FAIL rnd%0d_stall_stable got=%0d exp=0", round, unstable); end
         checks++; if (done_pulses != 1) begin errors++; $display("FAIL rnd%0d_done got=%0d exp=1", round, done_pulses); end
         checks++; if (beat_end != 64) begin errors++; $display("FAIL rnd%0d_beat_cnt got=%0d exp=64", round, beat_end); end
         $display("random round %0d: op %0d, %0d results", round, rop, got_d.size());
      end
      a_pct = 100; b_pct = 100; r_pct = 100;
   endtask

   task automatic test_len_zero_and_busy_start();
      clear_stim();
      run_stream(VFPU_ADD, 0, 1'b1);
      checks++; if (done_cyc != 0) begin errors++; $display("FAIL len0_done_cycle got=%0d exp=0", done_cyc); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL len0_done_pulses got=%0d exp=1", done_pulses); end
      checks++; if (fire_count != 0) begin errors++; $display("FAIL len0_ready got=%0d exp=0", fire_count); end
      checks++; if (rvalid_count != 0) begin errors++; $display("FAIL len0_rvalid got=%0d exp=0", rvalid_count); end
      $display("len0: done at cycle %0d", done_cyc);
      clear_stim();
      for (int i = 0; i < 16; i++) begin
         stim_a.push_back({$urandom, $urandom}); stim_b.push_back({$urandom, $urandom});
         stim_sa.push_back('1); stim_sb.push_back(SW'($urandom));
      end
      a_pct = 100; b_pct = 100; r_pct = 50; inject_cyc = 3;
      run_stream(VFPU_ADD, 16, 1'b0);
      checks++; if (busy_at_inject !== 1'b1) begin errors++; $display("FAIL busy_start_busy got=%b exp=1", busy_at_inject); end
      checks++; if (got_d.size() != 16) begin errors++; $display("FAIL busy_start_count got=%0d exp=16", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 16; i++) begin
         checks++;
         if (got_d[i] !== beat_model(VFPU_ADD, stim_a[i], stim_b[i])) begin
            errors++; $display("FAIL busy_start_beat%0d got=%h exp=%h", i, got_d[i], beat_model(VFPU_ADD, stim_a[i], stim_b[i]));
         end
      end
      checks++; if (beat_end != 16 || done_pulses != 1) begin errors++; $display("FAIL busy_start_end got=%0d/%0d exp=16/1", beat_end, done_pulses); end
      r_pct = 100;
      $display("busy start: %0d results", got_d.size());
   endtask

   task automatic start_partial_job();
      @(posedge clk); #1;
      start = 1'b1; op = VFPU_ADD; len = CW'(8);
      @(posedge clk); #1;
      start = 1'b0;
      r_if.ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         a_if.valid = 1'b1; b_if.valid = 1'b1;
         a_if.data = {$urandom, $urandom}; b_if.data = {$urandom, $urandom};
         a_if.strb = '1; b_if.strb = '1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_clear_reset();
      start_partial_job();
      checks++; if (busy !== 1'b1 || r_if.valid !== 1'b1) begin errors++; $display("FAIL preclear_active got=%b%b exp=11", busy, r_if.valid); end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      checks++; if (r_if.valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_idle got=%b%b exp=00", r_if.valid, busy); end
      checks++; if (beat_cnt !== '0) begin errors++; $display("FAIL clear_beat_cnt got=%0d exp=0", beat_cnt); end
      checks++; if (a_if.ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", a_if.ready); end
      $display("clear: pipeline flushed");
      start_partial_job();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (r_if.valid !== 1'b0 || busy !== 1'b0 || beat_cnt !== '0) begin
         errors++; $display("FAIL rst_mid_job got=%b%b/%0d exp=00/0", r_if.valid, busy, beat_cnt);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      a_if.valid = 1'b0; b_if.valid = 1'b0; r_if.ready = 1'b0;
      $display("reset mid-job: outputs idle");
      clear_stim();
      for (int i = 0; i < 6; i++) begin
         stim_a.push_back({$urandom, $urandom}); stim_b.push_back({$urandom, $urandom});
         stim_sa.push_back(SW'($urandom)); stim_sb.push_back(SW'($urandom));
      end
      a_pct = 80; b_pct = 80; r_pct = 70;
      run_stream(VFPU_SUB, 6, 1'b0);
      checks++; if (got_d.size() != 6 || beat_end != 6) begin errors++; $display("FAIL after_clear_count got=%0d/%0d exp=6/6", got_d.size(), beat_end); end
      for (int i = 0; i < got_d.size() && i < 6; i++) begin
         checks++;
         if (got_d[i] !== beat_model(VFPU_SUB, stim_a[i], stim_b[i]) || got_s[i] !== (stim_sa[i] & stim_sb[i])) begin
            errors++; $display("FAIL after_clear_beat%0d got=%h exp=%h", i, got_d[i], beat_model(VFPU_SUB, stim_a[i], stim_b[i]));
         end
      end
      $display("post-clear job: %0d results", got_d.size());
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; start = 1'b0; op = '0; len = '0;
      a_if.valid = 1'b0; b_if.valid = 1'b0; r_if.ready = 1'b0;
      a_if.data = '0; b_if.data = '0; a_if.strb = '0; b_if.strb = '0;
      test_reset();
      test_add_basic();
      test_saturation();
      test_mul_min_max();
      test_random();
      test_len_zero_and_busy_start();
      test_clear_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
